// File: rtl/crc_32_chk_gtx.sv
// Receive-side Ethernet FCS checker. It strips the 4-byte FCS, forwards the payload and reports per-frame status.
// Latency is 5 cycles from byte in to byte out, with no backpressure. Define CRC_STAT_EN to build the good/bad frame counters.
module crc_32_chk_gtx #(
   parameter int MAX_LEN = 1518,
   parameter int LEN_W   = 11
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [7:0]       rx_data,
   input  logic             rx_data_valid,
   output logic [7:0]       tx_data,
   output logic             tx_data_valid,
   output logic             tx_sof,
   output logic             frame_done,
   output logic             crc_ok,
   output logic             crc_err,
   output logic             runt_err,
   output logic             len_err,
   output logic [LEN_W-1:0] frame_len,
   output logic [15:0]      good_cnt,
   output logic [15:0]      err_cnt
);
   typedef enum logic [2:0] {WAIT, IDLE, FILL, PASS, DONE} state_t;

   localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
   localparam logic [LEN_W-1:0] RUNT_LEN  = LEN_W'(4);

   state_t           state;
   logic [3:0][7:0]  dl;          // dl[0] is the oldest byte; at end of frame dl holds the FCS
   logic [31:0]      crc;
   logic [LEN_W-1:0] len;
   logic [LEN_W-1:0] len_inc;
   logic             first_out;
   logic             is_runt;
   logic             is_long;
   logic             fcs_bad;

   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c ^ {24'd0, d};
      for (int i = 0; i < 8; i++) begin
         r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
      end
      return r;
   endfunction

   assign len_inc = (len == '1) ? len : len + 1'b1;
   assign is_runt = (len <= RUNT_LEN);
   assign is_long = (len > MAX_LEN_L);
   assign fcs_bad = !is_runt && (dl != ~crc);

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= WAIT;
         dl            <= '0;
         crc           <= 32'hFFFFFFFF;
         len           <= '0;
         first_out     <= 1'b0;
         tx_data       <= '0;
         tx_data_valid <= 1'b0;
         tx_sof        <= 1'b0;
         frame_done    <= 1'b0;
         crc_ok        <= 1'b0;
         crc_err       <= 1'b0;
         runt_err      <= 1'b0;
         len_err       <= 1'b0;
         frame_len     <= '0;
      end else begin
         tx_data_valid <= 1'b0;
         tx_sof        <= 1'b0;
         frame_done    <= 1'b0;
         crc_ok        <= 1'b0;
         crc_err       <= 1'b0;
         runt_err      <= 1'b0;
         len_err       <= 1'b0;
         frame_len     <= '0;
         case (state)
            WAIT: begin
               if (!rx_data_valid) state <= IDLE;
            end
            IDLE: begin
               if (rx_data_valid) begin
                  dl    <= {rx_data, dl[3:1]};
                  len   <= LEN_W'(1);
                  crc   <= 32'hFFFFFFFF;
                  state <= FILL;
               end
            end
            FILL, PASS: begin
               if (rx_data_valid) begin
                  dl  <= {rx_data, dl[3:1]};
                  len <= len_inc;
                  if (state == PASS) begin
                     tx_data       <= dl[0];
                     tx_data_valid <= 1'b1;
                     tx_sof        <= first_out;
                     first_out     <= 1'b0;
                     crc           <= crc_byte(crc, dl[0]);
                  end else if (len == LEN_W'(3)) begin
                     first_out <= 1'b1;
                     state     <= PASS;
                  end
               end else begin
                  // Status is registered here so it is presented during the DONE cycle
                  frame_done <= 1'b1;
                  frame_len  <= len;
                  runt_err   <= is_runt;
                  len_err    <= is_long;
                  crc_err    <= fcs_bad;
                  crc_ok     <= !(is_runt || is_long || fcs_bad);
                  first_out  <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: begin
               crc <= 32'hFFFFFFFF;
               if (rx_data_valid) begin
                  dl    <= {rx_data, dl[3:1]};
                  len   <= LEN_W'(1);
                  state <= FILL;
               end else begin
                  state <= IDLE;
               end
            end
            default: state <= WAIT;
         endcase
      end
   end

`ifdef CRC_STAT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         good_cnt <= '0;
         err_cnt  <= '0;
      end else if (frame_done) begin
         if (crc_ok) begin
            if (good_cnt != 16'hFFFF) good_cnt <= good_cnt + 1'b1;
         end else begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
         end
      end
   end
`else
   assign good_cnt = '0;
   assign err_cnt  = '0;
`endif

endmodule

// File: tb/tb_crc_32_chk_gtx.sv
// Directed bench for crc_32_chk_gtx: good, corrupt, runt, back-to-back, oversize and mid-frame reset frames.
module tb_crc_32_chk_gtx;
   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_data_valid;
   logic [7:0]  tx_data;
   logic        tx_data_valid;
   logic        tx_sof;
   logic        frame_done;
   logic        crc_ok;
   logic        crc_err;
   logic        runt_err;
   logic        len_err;
   logic [10:0] frame_len;
   logic [15:0] good_cnt;
   logic [15:0] err_cnt;

   crc_32_chk_gtx #(.MAX_LEN(1518), .LEN_W(11)) dut (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_data_valid(rx_data_valid),
      .tx_data(tx_data), .tx_data_valid(tx_data_valid), .tx_sof(tx_sof),
      .frame_done(frame_done), .crc_ok(crc_ok), .crc_err(crc_err),
      .runt_err(runt_err), .len_err(len_err), .frame_len(frame_len),
      .good_cnt(good_cnt), .err_cnt(err_cnt)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int start_cyc = 0;
   int first_cyc = -1;
   int sof_cnt = 0;
   int fd_cnt = 0;
   int ok_cnt = 0;
   int excl_bad = 0;
   int stray = 0;
   logic [7:0]  sof_byte = 8'h00;
   logic        l_ok = 1'b0, l_crc = 1'b0, l_runt = 1'b0, l_len = 1'b0;
   logic [10:0] l_flen = '0;
   logic [7:0]  fr[$];
   logic [7:0]  exp_q[$];
   logic [7:0]  out_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (tx_data_valid) begin
         if (first_cyc < 0) first_cyc = cyc;
         out_q.push_back(tx_data);
      end
      if (tx_sof) begin
         sof_cnt++;
         sof_byte = tx_data;
      end
      if (frame_done) begin
         fd_cnt++;
         if (crc_ok) ok_cnt++;
         l_ok = crc_ok; l_crc = crc_err; l_runt = runt_err; l_len = len_err; l_flen = frame_len;
         if (crc_ok == (crc_err | runt_err | len_err)) excl_bad++;
      end else if (crc_ok | crc_err | runt_err | len_err | (frame_len != 0)) begin
         stray++;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int b = 0; b < 8; b++) begin
         if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
         else             r = r >> 1;
      end
      return r;
   endfunction

   task automatic add_fcs();
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (fr[i]) c = ref_crc(c, fr[i]);
      c = ~c;
      fr.push_back(c[7:0]);
      fr.push_back(c[15:8]);
      fr.push_back(c[23:16]);
      fr.push_back(c[31:24]);
   endtask

   task automatic clear_mon();
      out_q.delete();
      exp_q.delete();
      fr.delete();
      first_cyc = -1;
      sof_cnt = 0;
      fd_cnt = 0;
      ok_cnt = 0;
   endtask

   task automatic drive_frame();
      foreach (fr[i]) begin
         @(negedge clk);
         rx_data = fr[i];
         rx_data_valid = 1'b1;
         if (i == 0) start_cyc = cyc;
      end
      @(negedge clk);
      rx_data_valid = 1'b0;
      rx_data = 8'h00;
      fr.delete();
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_payload(input string tag);
      int mism;
      mism = 0;
      chk({tag, "_count"}, out_q.size(), exp_q.size());
      if (out_q.size() == exp_q.size())
         foreach (exp_q[i]) if (out_q[i] !== exp_q[i]) mism++;
      chk({tag, "_bytes"}, mism, 0);
   endtask

   task automatic load_check_frame(input logic [7:0] last);
      for (int i = 0; i < 9; i++) begin
         fr.push_back(8'h31 + 8'(i));
         exp_q.push_back(8'h31 + 8'(i));
      end
      fr.push_back(8'h26); fr.push_back(8'h39); fr.push_back(8'hF4); fr.push_back(last);
   endtask

   initial begin
      rst = 1'b1;
      rx_data = 8'h00;
      rx_data_valid = 1'b0;
      idle(3);
      chk("reset_outputs", 32'({tx_data, tx_data_valid, tx_sof, frame_done, crc_ok, crc_err,
                                runt_err, len_err, frame_len}), 32'd0);
      chk("reset_counters", 32'({good_cnt, err_cnt}), 32'd0);
      rst = 1'b0;
      idle(3);

      // Good frame "123456789" + FCS
      clear_mon();
      load_check_frame(8'hCB);
      drive_frame();
      idle(6);
      check_payload("good_payload");
      chk("good_latency", first_cyc - start_cyc, 5);
      chk("good_sof_cnt", sof_cnt, 1);
      chk("good_sof_byte", 32'(sof_byte), 32'h31);
      chk("good_done_cnt", fd_cnt, 1);
      chk("good_status", 32'({l_ok, l_crc, l_runt, l_len}), 32'b1000);
      chk("good_len", 32'(l_flen), 32'd13);

      // Corrupted last FCS byte
      clear_mon();
      load_check_frame(8'hCA);
      drive_frame();
      idle(6);
      check_payload("bad_payload");
      chk("bad_done_cnt", fd_cnt, 1);
      chk("bad_status", 32'({l_ok, l_crc, l_runt, l_len}), 32'b0100);
      chk("bad_len", 32'(l_flen), 32'd13);
`ifdef CRC_STAT_EN
      chk("bad_err_cnt", 32'(err_cnt), 32'd1);
      chk("bad_good_cnt", 32'(good_cnt), 32'd1);
`else
      chk("cnt_tied_a", 32'({good_cnt, err_cnt}), 32'd0);
`endif

      // Runt
      clear_mon();
      fr.push_back(8'hAA); fr.push_back(8'hBB); fr.push_back(8'hCC);
      drive_frame();
      idle(6);
      chk("runt_no_output", out_q.size(), 0);
      chk("runt_done_cnt", fd_cnt, 1);
      chk("runt_status", 32'({l_ok, l_crc, l_runt, l_len}), 32'b0010);
      chk("runt_len", 32'(l_flen), 32'd3);

      // Back-to-back 64-byte frames after a counter-clearing reset
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      idle(2);
      clear_mon();
      for (int i = 0; i < 60; i++) begin
         fr.push_back(8'(i * 7 + 1));
         exp_q.push_back(8'(i * 7 + 1));
      end
      add_fcs();
      drive_frame();
      for (int i = 0; i < 60; i++) begin
         fr.push_back(8'(i) ^ 8'h5A);
         exp_q.push_back(8'(i) ^ 8'h5A);
      end
      add_fcs();
      drive_frame();
      idle(6);
      check_payload("b2b_payload");
      chk("b2b_done_cnt", fd_cnt, 2);
      chk("b2b_ok_cnt", ok_cnt, 2);
      chk("b2b_sof_cnt", sof_cnt, 2);
      chk("b2b_len", 32'(l_flen), 32'd64);
`ifdef CRC_STAT_EN
      chk("b2b_good_cnt", 32'(good_cnt), 32'd2);
`endif

      // Oversize 1519-byte frame with correct FCS
      clear_mon();
      for (int i = 0; i < 1515; i++) begin
         fr.push_back(8'(i) ^ 8'hC3);
         exp_q.push_back(8'(i) ^ 8'hC3);
      end
      add_fcs();
      drive_frame();
      idle(6);
      check_payload("long_payload");
      chk("long_done_cnt", fd_cnt, 1);
      chk("long_status", 32'({l_ok, l_crc, l_runt, l_len}), 32'b0001);
      chk("long_len", 32'(l_flen), 32'd1519);
`ifdef CRC_STAT_EN
      chk("long_err_cnt", 32'(err_cnt), 32'd1);
`endif

      // Reset pulsed at byte 20 while valid stays high
      clear_mon();
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (i == 21)
            chk("midrst_clear", 32'({tx_data, tx_data_valid, tx_sof, frame_done, crc_ok}), 32'd0);
         rx_data = 8'(i + 1);
         rx_data_valid = 1'b1;
         rst = (i == 20);
      end
      @(negedge clk);
      rx_data_valid = 1'b0;
      rx_data = 8'h00;
      rst = 1'b0;
      idle(4);
      chk("midrst_no_done", fd_cnt, 0);
      clear_mon();
      load_check_frame(8'hCB);
      drive_frame();
      idle(6);
      check_payload("post_rst_payload");
      chk("post_rst_done", fd_cnt, 1);
      chk("post_rst_ok", 32'(l_ok), 32'd1);
`ifdef CRC_STAT_EN
      chk("post_rst_cnts", 32'({good_cnt, err_cnt}), {16'd1, 16'd0});
`else
      chk("cnt_tied_b", 32'({good_cnt, err_cnt}), 32'd0);
`endif

      chk("status_exclusive", excl_bad, 0);
      chk("status_only_on_done", stray, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
